// File: rtl/debounce_entrada_pkg.sv
// debounce_entrada_pkg: state encoding, widths and
// saturating increment helpers for the entry debouncer.
package debounce_entrada_pkg;

  typedef enum logic [1:0] {
    SOLTO       = 2'd0,
    CONF_PRESS  = 2'd1,
    PRESSIONADO = 2'd2,
    CONF_SOLTA  = 2'd3
  } estado_t;

  localparam int CNT_W = 8;
  localparam int TMR_W = 16;

  function automatic logic [CNT_W-1:0] cnt_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [TMR_W-1:0] tmr_inc(
    input logic [TMR_W-1:0] v
  );
    return (&v) ? v : v + TMR_W'(1);
  endfunction

endpackage

// File: rtl/debounce_entrada_sincronizador_2ff.sv
// sincronizador_2ff: two-flop synchronizer for one
// asynchronous bit, synchronous active-high clear.
module sincronizador_2ff (
  input  logic clock,
  input  logic clear,
  input  logic i_d,
  output logic o_q
);

  logic r_ff1;
  logic r_ff2;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_ff1 <= 1'b0;
      r_ff2 <= 1'b0;
    end else begin
      r_ff1 <= i_d;
      r_ff2 <= r_ff1;
    end
  end

  assign o_q = r_ff2;

endmodule

// File: rtl/debounce_entrada.sv
// debounce_entrada: sync + debounce of the entry button, with press
// pulse; long-press pulse when DEBOUNCE_ENTRADA_LONG_PRESS_EN is defined.
module debounce_entrada
  import debounce_entrada_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int LONG_CYCLES     = 64
) (
  input  logic clock,
  input  logic clear,
  input  logic botao,
  output logic nivel,
  output logic pulso,
  output logic pulso_longo
);

  if (DEBOUNCE_CYCLES < 2 ||
      DEBOUNCE_CYCLES > (2**CNT_W) - 1) begin : g_bad_db
    $error("DEBOUNCE_CYCLES out of range");
  end

  if (LONG_CYCLES < 2 ||
      LONG_CYCLES > (2**TMR_W) - 1) begin : g_bad_long
    $error("LONG_CYCLES out of range");
  end

  localparam logic [CNT_W-1:0] LP_CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic w_s;

  estado_t          r_estado;
  estado_t          w_estado_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_nivel;
  logic             w_nivel_nxt;
  logic             r_pulso;
  logic             w_pulso_nxt;

  sincronizador_2ff u_sync (
    .clock (clock),
    .clear (clear),
    .i_d   (botao),
    .o_q   (w_s)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      r_estado <= SOLTO;
      r_cnt    <= '0;
      r_nivel  <= 1'b0;
      r_pulso  <= 1'b0;
    end else begin
      r_estado <= w_estado_nxt;
      r_cnt    <= w_cnt_nxt;
      r_nivel  <= w_nivel_nxt;
      r_pulso  <= w_pulso_nxt;
    end
  end

  always_comb begin
    w_estado_nxt = r_estado;
    w_cnt_nxt    = r_cnt;
    w_pulso_nxt  = 1'b0;
    unique case (r_estado)
      SOLTO: begin
        if (w_s) begin
          w_estado_nxt = CONF_PRESS;
          w_cnt_nxt    = CNT_W'(1);
        end
      end
      CONF_PRESS: begin
        if (!w_s) begin
          w_estado_nxt = SOLTO;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_estado_nxt = PRESSIONADO;
          w_pulso_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = cnt_inc(r_cnt);
        end
      end
      PRESSIONADO: begin
        if (!w_s) begin
          w_estado_nxt = CONF_SOLTA;
          w_cnt_nxt    = CNT_W'(1);
        end
      end
      CONF_SOLTA: begin
        if (w_s) begin
          w_estado_nxt = PRESSIONADO;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_estado_nxt = SOLTO;
        end else begin
          w_cnt_nxt = cnt_inc(r_cnt);
        end
      end
    endcase
    w_nivel_nxt = (w_estado_nxt == PRESSIONADO) ||
                  (w_estado_nxt == CONF_SOLTA);
  end

  assign nivel = r_nivel;
  assign pulso = r_pulso;

`ifdef DEBOUNCE_ENTRADA_LONG_PRESS_EN
  localparam logic [TMR_W-1:0] LP_LONG_LAST =
    TMR_W'(LONG_CYCLES - 1);

  logic [TMR_W-1:0] r_tmr;
  logic             r_pulso_longo;
  logic             w_segura;

  // held now and still held after this edge
  assign w_segura = r_nivel && (w_estado_nxt != SOLTO);

  always_ff @(posedge clock) begin
    if (clear) begin
      r_tmr         <= '0;
      r_pulso_longo <= 1'b0;
    end else begin
      r_pulso_longo <= 1'b0;
      if (w_pulso_nxt) begin
        r_tmr <= '0;
      end else if (w_segura) begin
        r_tmr         <= tmr_inc(r_tmr);
        r_pulso_longo <= (r_tmr == LP_LONG_LAST);
      end else begin
        r_tmr <= '0;
      end
    end
  end

  assign pulso_longo = r_pulso_longo;
`else
  assign pulso_longo = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_entrada.sv
// tb_debounce_entrada: directed + random stimulus against a
// run-length reference model of the debouncer.
module tb_debounce_entrada;

  localparam int DC = 4;
  localparam int LC = 16;

  logic clock = 1'b0;
  logic clear = 1'b1;
  logic botao = 1'b0;
  logic nivel;
  logic pulso;
  logic pulso_longo;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  // reference model state
  logic m_s1, m_s2, m_lv, m_pl, m_pll;
  int   m_run, m_k;

  // observed event bookkeeping
  int   n_pulso = 0, last_pulso = -1;
  int   n_longo = 0, last_longo = -1;
  int   last_fall = -1;
  logic prev_nivel = 1'b0;

  debounce_entrada #(
    .DEBOUNCE_CYCLES (DC),
    .LONG_CYCLES     (LC)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .botao       (botao),
    .nivel       (nivel),
    .pulso       (pulso),
    .pulso_longo (pulso_longo)
  );

  always #5 clock = ~clock;

  task automatic chk_bit(input string tag, input logic obs,
                         input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @edge %0d: observed %b expected %b",
             tag, edge_n, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs,
                         input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Level flips after DC consecutive synchronized samples that
  // disagree with it; s lags botao by two edges.
  task automatic model_edge(input logic b, input logic c);
    logic s, was;
    m_pl  = 1'b0;
    m_pll = 1'b0;
    if (c) begin
      m_s1 = 0; m_s2 = 0; m_lv = 0; m_run = 0; m_k = 0;
      return;
    end
    s    = m_s2;
    m_s2 = m_s1;
    m_s1 = b;
    was  = m_lv;
    if (s != m_lv) begin
      m_run++;
      if (m_run == DC) begin
        m_lv  = s;
        m_run = 0;
        m_k   = 0;
        m_pl  = s;
      end
    end else begin
      m_run = 0;
    end
    if (was && m_lv) begin
      if (m_k < 65535) m_k++;
      if (m_k == LC) m_pll = 1'b1;
    end
  endtask

  task automatic step(input logic b, input logic c);
    logic exp_l;
    botao = b;
    clear = c;
    @(posedge clock);
    model_edge(b, c);
    edge_n++;
    #1;
`ifdef DEBOUNCE_ENTRADA_LONG_PRESS_EN
    exp_l = m_pll;
`else
    exp_l = 1'b0;
`endif
    chk_bit("nivel", nivel, m_lv);
    chk_bit("pulso", pulso, m_pl);
    chk_bit("pulso_longo", pulso_longo, exp_l);
    if (pulso === 1'b1) begin
      n_pulso++;
      last_pulso = edge_n;
    end
    if (pulso_longo === 1'b1) begin
      n_longo++;
      last_longo = edge_n;
    end
    if (prev_nivel === 1'b1 && nivel === 1'b0)
      last_fall = edge_n;
    prev_nivel = nivel;
  endtask

  task automatic run(input logic b, input logic c, input int n);
    for (int i = 0; i < n; i++) step(b, c);
  endtask

  initial begin
    int base, t0, len;
    logic rb, rc;

    // reset and clean press from edge 10
    step(1'b0, 1'b1);
    chk_bit("reset_nivel", nivel, 1'b0);
    chk_bit("reset_pulso", pulso, 1'b0);
    run(1'b0, 1'b0, 8);
    chk_int("pre_press_edge", edge_n, 9);
    run(1'b1, 1'b0, 50);
    chk_int("press_edge", last_pulso, 15);
    chk_int("press_count", n_pulso, 1);
    chk_bit("press_nivel", nivel, 1'b1);
`ifdef DEBOUNCE_ENTRADA_LONG_PRESS_EN
    chk_int("long_edge", last_longo, 15 + LC);
    chk_int("long_count", n_longo, 1);
`else
    chk_int("long_count", n_longo, 0);
`endif

    // release glitch of two cycles
    run(1'b0, 1'b0, 2);
    run(1'b1, 1'b0, 10);
    chk_bit("glitch_nivel", nivel, 1'b1);
    chk_int("glitch_pulses", n_pulso, 1);

    // real release
    t0 = edge_n + 1;
    run(1'b0, 1'b0, 12);
    chk_int("release_edge", last_fall, t0 + DC + 1);
    chk_bit("release_nivel", nivel, 1'b0);
`ifdef DEBOUNCE_ENTRADA_LONG_PRESS_EN
    chk_int("long_once", n_longo, 1);
`else
    chk_int("long_none", n_longo, 0);
`endif

    // bounce 1,0,1,0 then low
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    run(1'b0, 1'b0, 10);
    chk_int("bounce_pulses", n_pulso, 1);
    chk_bit("bounce_nivel", nivel, 1'b0);

    // new press after release
    t0 = edge_n + 1;
    run(1'b1, 1'b0, 10);
    chk_int("repress_pulses", n_pulso, 2);
    chk_int("repress_edge", last_pulso, t0 + DC + 1);
    run(1'b0, 1'b0, 10);

    // clear while confirming a press
    run(1'b1, 1'b0, 3);
    step(1'b1, 1'b1);
    chk_bit("midclr_nivel", nivel, 1'b0);
    chk_bit("midclr_pulso", pulso, 1'b0);
    base = n_pulso;
    t0   = edge_n + 1;
    run(1'b1, 1'b0, 12);
    chk_int("midclr_pulses", n_pulso, base + 1);
    chk_int("midclr_edge", last_pulso, t0 + DC + 1);
    run(1'b0, 1'b0, 10);

    // random segments with occasional clear
    len = 0;
    rb  = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (len == 0) begin
        rb  = 1'($urandom_range(0, 1));
        len = $urandom_range(1, 3 * DC);
        if ($urandom_range(0, 7) == 0) len += LC + 4;
      end
      rc = ($urandom_range(0, 60) == 0);
      step(rb, rc);
      len--;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
